x2p_map_loader: RTL and testbench
=================================

# x2p_map_loader

APB initiator that fetches the slave address map (start/end address per APB slave) from the bridge's address-map register block and holds it in a local table. It runs automatically after reset and again on request. It checks each entry and exposes the map, plus valid/error status, to the AXI-to-APB decode logic. It sits on the register-block APB port as its only requester.

## Interface
Parameters:
- SLAVE_CNT, 4: number of APB slaves in the map, legal 1..4; the block reads 2*SLAVE_CNT words.
- TIMEOUT, 16: maximum ACCESS-phase cycles with pready low before the transfer aborts; legal 2..255.

Ports:
- pclk  in  1  clock, all logic on the rising edge.
- preset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle reload request; ignored while busy.
- psel  out  1  APB select.
- penable  out  1  APB enable, high in the ACCESS phase.
- paddr  out  32  register byte address, equal to idx*4.
- pwrite  out  1  constant 0; the block only reads.
- pwdata  out  32  constant 0.
- pstrb  out  4  constant 0.
- pprot  out  3  constant 3'b000.
- prdata  in  32  read data from the register block.
- pready  in  1  transfer completion; tie high for zero-wait responders.
- pslverr  in  1  error response, sampled only when pready is high.
- slv_start  out  32*SLAVE_CNT  start address of slave k at bits [32k+31:32k].
- slv_end  out  32*SLAVE_CNT  end address of slave k at bits [32k+31:32k].
- busy  out  1  a load is in progress.
- map_valid  out  1  the table is complete and consistent.
- map_err  out  1  the last load aborted.
- err_code  out  2  cause of abort: 00 none, 01 pslverr, 10 timeout, 11 range (end < start).
- err_idx  out  3  word index (0..7) at which the abort occurred.

## Operation
- FSM states:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0; lasts exactly 1 cycle.
  - ACCESS: psel=1, penable=1.
- Internal signals: word counter idx (3 bits) and wait counter wcnt (8 bits).
- Auto-load:
  - Reset sets an internal pending flag.
  - The first posedge after preset_n deasserts moves IDLE to SETUP with idx=0.
- start:
  - start=1 in IDLE clears map_valid, map_err, err_code and err_idx; moves to SETUP with idx=0.
  - start=1 while busy is ignored and not queued.
- ACCESS, pready=0:
  - wcnt increments.
  - When wcnt reaches TIMEOUT-1 without pready, the block aborts with err_code=10 and goes to IDLE.
- ACCESS, pready=1 and pslverr=1: abort with err_code=01. The table word is not written.
- ACCESS, pready=1 and pslverr=0:
  - Write prdata into table word idx: even idx goes to slv_start[idx/2], odd idx goes to slv_end[idx/2].
  - Range check on odd idx: if prdata < stored start (unsigned), abort with err_code=11. The word is still written.
  - If idx == 2*SLAVE_CNT-1: set map_valid and go to IDLE.
  - Otherwise: idx+1, clear wcnt, go to SETUP.
- Every abort: map_err=1, err_idx=idx, map_valid stays 0, FSM goes to IDLE.
- Previous table contents persist across a reload until overwritten; consumers must gate on map_valid.
- Outputs paddr, psel and penable are registered; paddr is held stable from SETUP through the end of ACCESS.

## Timing
- Reset values:
  - psel, penable, busy, map_valid, map_err = 0.
  - paddr, err_code, err_idx = 0.
  - All slv_start/slv_end = 0.
  - FSM = IDLE, pending = 1.
- Reset asserted mid-transfer:
  - psel and penable drop asynchronously.
  - The table clears.
  - A new auto-load begins after release.
- busy is high from the edge that enters SETUP for idx 0 until the edge that returns to IDLE.
- Zero-wait timing (pready=1), counting edges after reset release:
  - Word k completes at edge 3+2k.
  - map_valid rises at edge 4*SLAVE_CNT+1 (edge 17 for SLAVE_CNT=4).
- Each wait state adds exactly one cycle.
- Timeout abort occurs on the TIMEOUT-th ACCESS cycle.
- IDLE lasts at least 1 cycle between loads; start sampled on the completion edge is ignored.

## Test plan
- Zero-wait load, SLAVE_CNT=4, responder returns {0x1000,0x1FFF,0x2000,0x2FFF,0x3000,0x3FFF,0x4000,0x4FFF}:
  - paddr sequence is 0x00..0x1C.
  - map_valid=1 at edge 17; table matches; pwrite stays 0.
- pready low for 3 cycles on word 2 → load completes 3 cycles later than the zero-wait case; paddr is held at 0x08 throughout the wait.
- pslverr=1 on word 5 → map_err=1, err_code=01, err_idx=5, map_valid=0, slv_end[2] unchanged.
- pready stuck low on word 0, TIMEOUT=16 → abort after 16 ACCESS cycles with err_code=10, err_idx=0; psel=0 on the next cycle.
- Word 3 returns 0x0FFF with start 0x2000 → err_code=11, err_idx=3.
- Error cases:
  - start mid-load → ignored; load completes normally.
  - preset_n asserted during word 4 → psel=0 immediately; a fresh load after release completes with map_valid=1.

Source files
------------

// File: rtl/x2p_map_loader.sv
// x2p_map_loader
//   APB read initiator that pulls the slave address map (start/end word pair
//   per APB slave) out of the bridge register block into a local table. It
//   loads automatically once reset is released, and again on each start
//   pulse taken while idle. Each pair is range checked. The table is exposed
//   together with valid/error status for the AXI-to-APB decode logic.
//
// Ports
//   pclk, preset_n        clock, asynchronous active-low reset
//   start                 reload request (ignored while busy)
//   psel..pprot           APB requester outputs (read only)
//   prdata/pready/pslverr APB responder inputs
//   slv_start, slv_end    map table, slave k at bits [32k+31:32k]
//   busy                  a load is in progress
//   map_valid             table complete and consistent
//   map_err, err_code     last load aborted, and why (01 slverr, 10 timeout, 11 range)
//   err_idx               word index at which the abort happened
//
// state  | meaning
// IDLE   | no transfer; waits for the pending auto-load or a start pulse
// SETUP  | APB setup phase for word idx (one cycle)
// ACCESS | APB access phase; waits for pready, counting wait states
module x2p_map_loader #(
  parameter int SLAVE_CNT = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                     pclk,
  input  logic                     preset_n,
  input  logic                     start,
  output logic                     psel,
  output logic                     penable,
  output logic [31:0]              paddr,
  output logic                     pwrite,
  output logic [31:0]              pwdata,
  output logic [3:0]               pstrb,
  output logic [2:0]               pprot,
  input  logic [31:0]              prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic [32*SLAVE_CNT-1:0]  slv_start,
  output logic [32*SLAVE_CNT-1:0]  slv_end,
  output logic                     busy,
  output logic                     map_valid,
  output logic                     map_err,
  output logic [1:0]               err_code,
  output logic [2:0]               err_idx
);

  localparam logic [2:0] LAST_IDX = 3'(2*SLAVE_CNT-1);
  localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [7:0]  wcnt;
  logic        pending;
  logic [31:0] start_tbl [SLAVE_CNT];
  logic [31:0] end_tbl   [SLAVE_CNT];

  logic        load, wr, abort, done, advance, wait_inc;
  logic [1:0]  abort_code;

  assign pwrite = 1'b0;
  assign pwdata = '0;
  assign pstrb  = '0;
  assign pprot  = 3'b000;
  assign busy   = (state != S_IDLE);

  for (genvar k = 0; k < SLAVE_CNT; k++) begin : g_flat
    assign slv_start[32*k +: 32] = start_tbl[k];
    assign slv_end[32*k +: 32]   = end_tbl[k];
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    wr         = 1'b0;
    abort      = 1'b0;
    abort_code = 2'b00;
    done       = 1'b0;
    advance    = 1'b0;
    wait_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending || start) begin
          load      = 1'b1;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: state_nxt = S_ACCESS;
      S_ACCESS: begin
        if (!pready) begin
          if (wcnt == WAIT_MAX) begin
            abort      = 1'b1;
            abort_code = 2'b10;
            state_nxt  = S_IDLE;
          end else begin
            wait_inc = 1'b1;
          end
        end else if (pslverr) begin
          abort      = 1'b1;
          abort_code = 2'b01;
          state_nxt  = S_IDLE;
        end else begin
          wr = 1'b1;
          // end word below its start: the word is kept, but the map is bad
          if (idx[0] && (prdata < start_tbl[idx[2:1]])) begin
            abort      = 1'b1;
            abort_code = 2'b11;
            state_nxt  = S_IDLE;
          end else if (idx == LAST_IDX) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            advance   = 1'b1;
            state_nxt = S_SETUP;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pending   <= 1'b1;
      idx       <= '0;
      wcnt      <= '0;
      paddr     <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      map_valid <= 1'b0;
      map_err   <= 1'b0;
      err_code  <= 2'b00;
      err_idx   <= '0;
      for (int k = 0; k < SLAVE_CNT; k++) begin
        start_tbl[k] <= '0;
        end_tbl[k]   <= '0;
      end
    end else begin
      psel    <= (state_nxt != S_IDLE);
      penable <= (state_nxt == S_ACCESS);
      if (load) begin
        pending   <= 1'b0;
        idx       <= '0;
        wcnt      <= '0;
        paddr     <= '0;
        map_valid <= 1'b0;
        map_err   <= 1'b0;
        err_code  <= 2'b00;
        err_idx   <= '0;
      end
      if (wait_inc) wcnt <= wcnt + 8'd1;
      if (wr) begin
        if (idx[0]) end_tbl[idx[2:1]]   <= prdata;
        else        start_tbl[idx[2:1]] <= prdata;
      end
      if (abort) begin
        map_err  <= 1'b1;
        err_code <= abort_code;
        err_idx  <= idx;
      end
      if (done) map_valid <= 1'b1;
      if (advance) begin
        idx   <= idx + 3'd1;
        wcnt  <= '0;
        paddr <= {27'd0, idx + 3'd1, 2'b00};
      end
    end
  end

endmodule

// File: tb/tb_x2p_map_loader.sv
module tb_x2p_map_loader;

  logic         pclk = 1'b0;
  logic         preset_n = 1'b0;
  logic         start = 1'b0;
  logic         psel, penable, pwrite;
  logic [31:0]  paddr, pwdata, prdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic         pready, pslverr;
  logic [127:0] slv_start, slv_end;
  logic         busy, map_valid, map_err;
  logic [1:0]   err_code;
  logic [2:0]   err_idx;

  x2p_map_loader #(.SLAVE_CNT(4), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .start(start),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .slv_start(slv_start), .slv_end(slv_end), .busy(busy),
    .map_valid(map_valid), .map_err(map_err), .err_code(err_code), .err_idx(err_idx)
  );

  always #5 pclk = ~pclk;

  // responder model
  logic [31:0] mem [8];
  int wait_word = -1;
  int wait_cycles = 0;
  int err_word = -1;
  int acc_cnt;

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  assign prdata  = mem[paddr[4:2]];
  assign pready  = !(psel && penable && (int'(paddr[4:2]) == wait_word) && (acc_cnt < wait_cycles));
  assign pslverr = psel && penable && (err_word >= 0) && (int'(paddr[4:2]) == err_word);

  localparam logic [127:0] START_OK = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
  localparam logic [127:0] END_OK   = {32'h4FFF, 32'h3FFF, 32'h2FFF, 32'h1FFF};

  typedef struct {
    int           wait_word;
    int           wait_cycles;
    int           err_word;
    int           bad_word;
    logic [31:0]  bad_val;
    int           exp_edge;
    int           exp_ncomp;
    logic         exp_valid;
    logic         exp_err;
    logic [1:0]   exp_code;
    logic [2:0]   exp_idx;
    logic [127:0] exp_start;
    logic [127:0] exp_end;
  } vec_t;

  vec_t vecs [10];
  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic load_mem(input logic [31:0] offset, input int bw, input logic [31:0] bv);
    for (int k = 0; k < 8; k++) begin
      mem[k] = 32'h1000 * 32'(k/2 + 1) + ((k % 2 == 1) ? 32'hFFF : 32'h0) + offset;
    end
    if (bw >= 0) mem[bw] = bv;
  endtask

  // Runs one load from the current negedge; edges counted from here.
  task automatic run_load(input int sp_a, input int sp_b, input int sp_c,
                          output int edges, output int ncomp, output int seq_bad,
                          output int hold_bad, output int const_bad,
                          output logic busy1, output logic valid1, output logic err1);
    int e;
    logic [31:0] setup_addr;
    e = 0; ncomp = 0; seq_bad = 0; hold_bad = 0; const_bad = 0;
    busy1 = 1'b0; valid1 = 1'b0; err1 = 1'b0; setup_addr = '0;
    while (1) begin
      start = ((e+1) == sp_a) || ((e+1) == sp_b) || ((e+1) == sp_c);
      @(posedge pclk);
      e++;
      #1;
      if (e == 1) begin
        busy1 = busy; valid1 = map_valid; err1 = map_err;
      end
      if ((e > 1 && !busy) || e >= 100) break;
      if (pwrite !== 1'b0 || pwdata !== 32'h0 || pstrb !== 4'h0 || pprot !== 3'h0) const_bad++;
      if (penable && !psel) hold_bad++;
      if (psel && !penable) setup_addr = paddr;
      if (psel && penable) begin
        if (paddr !== setup_addr) hold_bad++;
        if (pready) begin
          if (paddr !== 32'(ncomp*4)) seq_bad++;
          ncomp++;
        end
      end
    end
    start = 1'b0;
    edges = e;
  endtask

  int   edges, ncomp, seq_bad, hold_bad, const_bad, busy_seen;
  logic busy1, valid1, err1;

  initial begin
    vecs[0] = '{-1, 0,   -1, -1, 32'h0,    17, 8, 1'b1, 1'b0, 2'd0, 3'd0, START_OK, END_OK};
    vecs[1] = '{ 2, 3,   -1, -1, 32'h0,    20, 8, 1'b1, 1'b0, 2'd0, 3'd0, START_OK, END_OK};
    vecs[2] = '{ 7, 1,   -1, -1, 32'h0,    18, 8, 1'b1, 1'b0, 2'd0, 3'd0, START_OK, END_OK};
    vecs[3] = '{ 0, 15,  -1, -1, 32'h0,    32, 8, 1'b1, 1'b0, 2'd0, 3'd0, START_OK, END_OK};
    vecs[4] = '{-1, 0,    5, -1, 32'h0,    13, 6, 1'b0, 1'b1, 2'd1, 3'd5,
                {32'h0, 32'h3000, 32'h2000, 32'h1000}, {32'h0, 32'h0, 32'h2FFF, 32'h1FFF}};
    vecs[5] = '{ 0, 200, -1, -1, 32'h0,    18, 0, 1'b0, 1'b1, 2'd2, 3'd0, 128'h0, 128'h0};
    vecs[6] = '{ 6, 200, -1, -1, 32'h0,    30, 6, 1'b0, 1'b1, 2'd2, 3'd6,
                {32'h0, 32'h3000, 32'h2000, 32'h1000}, {32'h0, 32'h3FFF, 32'h2FFF, 32'h1FFF}};
    vecs[7] = '{-1, 0,   -1,  3, 32'h0FFF,  9, 4, 1'b0, 1'b1, 2'd3, 3'd3,
                {32'h0, 32'h0, 32'h2000, 32'h1000}, {32'h0, 32'h0, 32'h0FFF, 32'h1FFF}};
    vecs[8] = '{-1, 0,   -1,  1, 32'h1000, 17, 8, 1'b1, 1'b0, 2'd0, 3'd0,
                START_OK, {32'h4FFF, 32'h3FFF, 32'h2FFF, 32'h1000}};
    vecs[9] = '{-1, 0,   -1,  7, 32'h3FFF, 17, 8, 1'b0, 1'b1, 2'd3, 3'd7,
                START_OK, {32'h3FFF, 32'h3FFF, 32'h2FFF, 32'h1FFF}};

    load_mem(32'h0, -1, 32'h0);

    // reset values
    #12;
    chk("rst_psel", 128'(psel), 128'(1'b0));
    chk("rst_penable", 128'(penable), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_status", {map_valid, map_err, err_code, err_idx}, 128'h0);
    chk("rst_paddr", 128'(paddr), 128'h0);
    chk("rst_table", slv_start | slv_end, 128'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge pclk);
      preset_n = 1'b0;
      wait_word = vecs[i].wait_word;
      wait_cycles = vecs[i].wait_cycles;
      err_word = vecs[i].err_word;
      load_mem(32'h0, vecs[i].bad_word, vecs[i].bad_val);
      @(negedge pclk);
      preset_n = 1'b1;
      run_load(0, 0, 0, edges, ncomp, seq_bad, hold_bad, const_bad, busy1, valid1, err1);
      chk($sformatf("v%0d_busy_edge1", i), 128'(busy1), 128'(1'b1));
      chk($sformatf("v%0d_end_edge", i), 128'(edges), 128'(vecs[i].exp_edge));
      chk($sformatf("v%0d_ncomp", i), 128'(ncomp), 128'(vecs[i].exp_ncomp));
      chk($sformatf("v%0d_paddr_seq", i), 128'(seq_bad), 128'h0);
      chk($sformatf("v%0d_paddr_hold", i), 128'(hold_bad), 128'h0);
      chk($sformatf("v%0d_const_out", i), 128'(const_bad), 128'h0);
      chk($sformatf("v%0d_idle_bus", i), 128'({psel, penable}), 128'h0);
      chk($sformatf("v%0d_valid", i), 128'(map_valid), 128'(vecs[i].exp_valid));
      chk($sformatf("v%0d_err", i), 128'(map_err), 128'(vecs[i].exp_err));
      chk($sformatf("v%0d_code", i), 128'(err_code), 128'(vecs[i].exp_code));
      chk($sformatf("v%0d_idx", i), 128'(err_idx), 128'(vecs[i].exp_idx));
      chk($sformatf("v%0d_start", i), slv_start, vecs[i].exp_start);
      chk($sformatf("v%0d_end", i), slv_end, vecs[i].exp_end);
    end

    // reset asserted while word 4 is in ACCESS
    wait_word = -1; wait_cycles = 0; err_word = -1;
    load_mem(32'h0, -1, 32'h0);
    @(negedge pclk);
    preset_n = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    for (int k = 0; k < 10; k++) @(posedge pclk);
    #1;
    chk("mid_access_addr", {psel, penable, paddr}, {1'b1, 1'b1, 32'h10});
    #2;
    preset_n = 1'b0;
    #1;
    chk("mid_rst_bus", 128'({psel, penable, busy}), 128'h0);
    chk("mid_rst_table", slv_start | slv_end, 128'h0);
    @(negedge pclk);
    preset_n = 1'b1;
    run_load(0, 0, 0, edges, ncomp, seq_bad, hold_bad, const_bad, busy1, valid1, err1);
    chk("mid_rst_reload_edge", 128'(edges), 128'd17);
    chk("mid_rst_reload_valid", 128'(map_valid), 128'(1'b1));
    chk("mid_rst_reload_table", {slv_start, slv_end}, {START_OK, END_OK});

    // start reload, with extra start pulses mid-load and on the completion edge
    @(negedge pclk);
    run_load(1, 6, 17, edges, ncomp, seq_bad, hold_bad, const_bad, busy1, valid1, err1);
    chk("start_busy_edge1", 128'(busy1), 128'(1'b1));
    chk("start_clears_valid", 128'(valid1), 128'(1'b0));
    chk("start_mid_edge", 128'(edges), 128'd17);
    chk("start_mid_valid", 128'(map_valid), 128'(1'b1));
    busy_seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge pclk);
      #1;
      if (busy) busy_seen++;
    end
    chk("start_not_queued", 128'(busy_seen), 128'h0);

    // pslverr on word 5 over an existing map; untouched words persist
    @(negedge pclk);
    load_mem(32'h10000, -1, 32'h0);
    err_word = 5;
    run_load(1, 0, 0, edges, ncomp, seq_bad, hold_bad, const_bad, busy1, valid1, err1);
    chk("slverr_edge", 128'(edges), 128'd13);
    chk("slverr_status", {map_valid, map_err, err_code, err_idx}, {1'b0, 1'b1, 2'd1, 3'd5});
    chk("slverr_end2_kept", 128'(slv_end[95:64]), 128'h3FFF);
    chk("slverr_start2_new", 128'(slv_start[95:64]), 128'h13000);
    chk("slverr_end1_new", 128'(slv_end[63:32]), 128'h12FFF);

    // start after an abort clears the error status
    @(negedge pclk);
    load_mem(32'h0, -1, 32'h0);
    err_word = -1;
    run_load(1, 0, 0, edges, ncomp, seq_bad, hold_bad, const_bad, busy1, valid1, err1);
    chk("start_clears_err", 128'(err1), 128'(1'b0));
    chk("reload_edge", 128'(edges), 128'd17);
    chk("reload_status", {map_valid, map_err, err_code, err_idx}, {1'b1, 1'b0, 2'd0, 3'd0});
    chk("reload_table", {slv_start, slv_end}, {START_OK, END_OK});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
